// File: rtl/ap_fold_mult_seq.sv
// ap_fold_mult_seq: iterative unsigned WxW multiplier.
// Each COMP cycle folds two partial-product rows into a carry-save
// accumulator through one row of 4:2 compressors. A single
// carry-propagate add then resolves the product.
// Compile-time option: define APPROX_TRUNC_EN to zero the lowest
// TRUNC_COLS product columns before compression.
`timescale 1ns/1ps

module ap_fold_mult_seq #(
  parameter int unsigned W          = 8,
  parameter int unsigned TRUNC_COLS = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     a,
  input  logic [W-1:0]     b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*W-1:0]   product,
  output logic             busy
);

  localparam int unsigned PW    = 2 * W;
  localparam int unsigned ROWS  = W / 2;
  localparam int unsigned CNT_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned IDX_W = $clog2(W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ROWS - 1);

`ifdef APPROX_TRUNC_EN
  localparam int unsigned TRUNC_EFF = TRUNC_COLS;
`else
  // Exact build: every column is kept, TRUNC_COLS has no effect.
  localparam int unsigned TRUNC_EFF = TRUNC_COLS * 0;
`endif

  // Columns that may carry partial-product bits.
  localparam logic [PW-1:0] PP_MASK = {PW{1'b1}} << TRUNC_EFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    COMP = 2'd1,
    ADD  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [W-1:0]     a_q, a_d;
  logic [W-1:0]     b_q, b_d;
  logic [PW-1:0]    sum_q, sum_d;
  logic [PW-1:0]    carry_q, carry_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PW-1:0]    product_q, product_d;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             busy_q;

  logic [PW-1:0]    a_ext;
  logic [IDX_W-1:0] idx0, idx1;
  logic [PW-1:0]    pp0, pp1;
  logic [PW-1:0]    comp_sum;
  logic [PW-1:0]    comp_carry;

  assign a_ext = {{W{1'b0}}, a_q};

  // The two partial-product rows selected by the row counter.
  always_comb begin
    idx0 = IDX_W'({cnt_q, 1'b0});
    idx1 = IDX_W'({cnt_q, 1'b1});
    pp0  = b_q[idx0] ? ((a_ext << idx0) & PP_MASK) : '0;
    pp1  = b_q[idx1] ? ((a_ext << idx1) & PP_MASK) : '0;
  end

  // One 2W-column row of 4:2 compressors; the intermediate carry ripples
  // one column, the output carry vector is pre-shifted left by one.
  always_comb begin : comp_row
    logic cin;
    logic co_prev;
    logic s1;
    logic cout;
    logic co;
    cin        = 1'b0;
    co_prev    = 1'b0;
    s1         = 1'b0;
    cout       = 1'b0;
    co         = 1'b0;
    comp_sum   = '0;
    comp_carry = '0;
    for (int k = 0; k < int'(PW); k++) begin
      s1   = sum_q[k] ^ carry_q[k] ^ pp0[k];
      cout = (sum_q[k] & carry_q[k]) | (sum_q[k] & pp0[k]) | (carry_q[k] & pp0[k]);
      comp_sum[k]   = s1 ^ pp1[k] ^ cin;
      co            = (s1 & pp1[k]) | (s1 & cin) | (pp1[k] & cin);
      comp_carry[k] = co_prev;
      co_prev       = co;
      cin           = cout;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    sum_d     = sum_q;
    carry_d   = carry_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          a_d     = a;
          b_d     = b;
          sum_d   = '0;
          carry_d = '0;
          cnt_d   = '0;
          state_d = COMP;
        end
      end
      COMP: begin
        sum_d   = comp_sum;
        carry_d = comp_carry;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = ADD;
        end
      end
      ADD: begin
        product_d = sum_q + carry_q;
        state_d   = DONE;
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q       <= '0;
      b_q       <= '0;
      sum_q     <= '0;
      carry_q   <= '0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      a_q       <= a_d;
      b_q       <= b_d;
      sum_q     <= sum_d;
      carry_q   <= carry_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

  // Handshake/status flags registered from the next state; in_ready stays
  // low until the first edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      in_ready_q  <= (state_d == IDLE);
      out_valid_q <= (state_d == DONE);
      busy_q      <= (state_d != IDLE);
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign product   = product_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_ap_fold_mult_seq.sv
// Scoreboard bench for ap_fold_mult_seq: expected products are queued at
// acceptance and popped by a monitor on every output handshake.
`timescale 1ns/1ps

module tb_ap_fold_mult_seq;

  localparam int unsigned W          = 8;
  localparam int unsigned PW         = 2 * W;
  localparam int unsigned TRUNC_COLS = 4;
`ifdef APPROX_TRUNC_EN
  localparam int MODEL_TRUNC = int'(TRUNC_COLS);
`else
  localparam int MODEL_TRUNC = 0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          out_valid;
  logic          out_ready;
  logic [PW-1:0] product;
  logic          busy;

  int n_checks = 0;
  int n_fail   = 0;
  logic [PW-1:0] exp_q[$];

  ap_fold_mult_seq #(.W(W), .TRUNC_COLS(TRUNC_COLS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Reference: sum of a[j]*b[i]*2^(i+j) over the kept columns, mod 2^2W.
  function automatic logic [PW-1:0] ref_mult(input logic [W-1:0] x, input logic [W-1:0] y);
    longint unsigned acc;
    acc = 0;
    for (int i = 0; i < int'(W); i++)
      for (int j = 0; j < int'(W); j++)
        if (y[i] && x[j] && (i + j) >= MODEL_TRUNC)
          acc += (64'd1 << (i + j));
    return PW'(acc);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, exp_v, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: samples mid-cycle; handshakes seen here complete at the next edge.
  logic          hold_pending = 1'b0;
  logic [PW-1:0] hold_product;
  always @(negedge clk) begin
    if (!rst_n) begin
      hold_pending = 1'b0;
    end else begin
      if (hold_pending) begin
        check("hold_valid", 64'(out_valid), 64'd1);
        check("hold_product", 64'(product), 64'(hold_product));
      end
      if (in_valid && in_ready)
        exp_q.push_back(ref_mult(a, b));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_result: got product 0x%0h, required no output at %0t", product, $time);
        end else begin
          logic [PW-1:0] e;
          e = exp_q.pop_front();
          check("result", 64'(product), 64'(e));
        end
      end
      hold_pending = out_valid && !out_ready;
      hold_product = product;
    end
  end

  task automatic accept(input logic [W-1:0] av, input logic [W-1:0] bv);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) check("in_ready_timeout", 64'(in_ready), 64'd1);
    in_valid = 1'b1;
    a = av;
    b = bv;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_out();
    int n;
    n = 0;
    while (!out_valid && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) check("out_valid_timeout", 64'(out_valid), 64'd1);
  endtask

  task automatic drain();
    int n;
    out_ready = 1'b1;
    in_valid  = 1'b0;
    n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 100) begin
      tick();
      n++;
    end
    check("drain_queue", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lat;
    logic [W-1:0] va [3] = '{8'h00, 8'h01, 8'h80};
    logic [W-1:0] vb [3] = '{8'hA5, 8'hA5, 8'h80};

    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; out_ready = 1'b0;
    repeat (2) tick();
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_product", 64'(product), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    rst_n = 1'b1;
    #1;
    check("post_rst_in_ready_low", 64'(in_ready), 64'd0);
    tick();
    check("post_rst_in_ready_high", 64'(in_ready), 64'd1);

    // Exact corner with latency and recovery timing.
    out_ready = 1'b1;
    accept(8'hFF, 8'hFF);
    check("busy_after_accept", 64'(busy), 64'd1);
    lat = 0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    check("latency", 64'(lat), 64'd5);
`ifdef APPROX_TRUNC_EN
    check("corner_ff_ff", 64'(product), 64'h0000_FDD0);
`else
    check("corner_ff_ff", 64'(product), 64'h0000_FE01);
`endif
    tick();
    check("out_valid_cleared", 64'(out_valid), 64'd0);
    tick();
    check("in_ready_recovered", 64'(in_ready), 64'd1);
    check("busy_recovered", 64'(busy), 64'd0);

    // Zero, identity and power-of-two operands.
    for (int i = 0; i < 3; i++) begin
      accept(va[i], vb[i]);
      wait_out();
      check("directed_product", 64'(product), 64'(ref_mult(va[i], vb[i])));
      tick();
    end

    // Backpressure with ignored input pulses.
    out_ready = 1'b0;
    accept(8'h12, 8'h34);
    wait_out();
    for (int i = 0; i < 4; i++) begin
      check("bp_out_valid", 64'(out_valid), 64'd1);
      check("bp_in_ready", 64'(in_ready), 64'd0);
      in_valid = 1'b1;
      a = W'($urandom);
      b = W'($urandom);
      tick();
      in_valid = 1'b0;
    end
`ifndef APPROX_TRUNC_EN
    check("bp_product", 64'(product), 64'h0000_03A8);
`else
    check("bp_product", 64'(product), 64'(ref_mult(8'h12, 8'h34)));
`endif
    out_ready = 1'b1;
    tick();
    check("bp_release", 64'(out_valid), 64'd0);
    check("bp_nothing_queued", 64'(exp_q.size()), 64'd0);

    // Continuous in_valid with changing operands.
    in_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      a = W'($urandom);
      b = W'($urandom);
      tick();
    end
    drain();

    // Random traffic with random consumer stalls.
    for (int i = 0; i < 300; i++) begin
      in_valid  = ($urandom_range(0, 1) == 1);
      a         = W'($urandom);
      b         = W'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    drain();

    // Reset during COMP with cnt = 2, then a clean operation.
    accept(8'h5A, 8'hC3);
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check("midrst_in_ready", 64'(in_ready), 64'd0);
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_product", 64'(product), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    exp_q.delete();
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    check("midrst_release_in_ready", 64'(in_ready), 64'd0);
    tick();
    accept(8'h03, 8'h05);
    wait_out();
`ifndef APPROX_TRUNC_EN
    check("after_rst_product", 64'(product), 64'h0000_000F);
`else
    check("after_rst_product", 64'(product), 64'(ref_mult(8'h03, 8'h05)));
`endif
    drain();
    repeat (10) tick();
    check("final_idle", 64'(busy), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
